ex_forward_ctrl: RTL and testbench

EX_FORWARD_CTRL -- requirements
Module: ex_forward_ctrl

---
 rtl/ex_forward_ctrl_pkg.sv | 36 +++
 rtl/ex_forward_ctrl.sv | 85 ++++++++
 tb/tb_ex_forward_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ex_forward_ctrl_pkg.sv
// Shared CPU constants: ALU operand-select encodings, ALU opcodes and the
// EX->WB pipeline record used by the forwarding controller.
package ex_forward_ctrl_pkg;

  // ALU operand-select encodings. Code 2'b11 is decoded downstream as PC/imm.
  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_PCIMM = 2'b01;
  localparam logic [1:0] SEL_WB    = 2'b10;

  // ALU opcodes shared with the execute stage.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Destination fields carried from EX into WB.
  typedef struct packed {
    logic [4:0] rd;
    logic       regwen;
  } wb_reg_t;

  // An EX-stage source matches the WB writer when WB really writes that register.
  function automatic logic src_hit(input wb_reg_t wb, input logic [4:0] rs,
                                   input logic valid);
    return wb.regwen & (wb.rd == rs) & valid;
  endfunction

endpackage

// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding controller: tracks the instruction in WB and steers the
// ALU operands and branch comparator inputs to wb_val on a register match.
module ex_forward_ctrl
  import ex_forward_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwen,
  input  logic            ex_a_is_pc,
  input  logic            ex_b_is_imm,
  output logic [1:0]      asel,
  output logic [1:0]      bsel,
  output logic            br1_fwd,
  output logic            br2_fwd,
  output logic [4:0]      wb_rd,
  output logic            wb_regwen,
  output logic [XLEN-1:0] fwd_count
);

  wb_reg_t   wb_q;
  logic      hit1;
  logic      hit2;
  logic      any_hit;

  // EX->WB pipeline register: reset wins, then flush kills the write, then stall holds.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      wb_q.rd     <= 5'd0;
      wb_q.regwen <= 1'b0;
    end else if (!stall) begin
      wb_q.rd     <= ex_rd;
      wb_q.regwen <= ex_valid & ex_regwen & ~flush & (ex_rd != 5'd0);
    end else if (flush) begin
      wb_q.regwen <= 1'b0;
    end
  end

  // Source-register match against the WB writer; x0 never matches since its regwen is never set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    hit1    = 1'b0;
    hit2    = 1'b0;
    hit1    = src_hit(wb_q, ex_rs1, ex_valid);
    hit2    = src_hit(wb_q, ex_rs2, ex_valid);
    any_hit = hit1 | hit2;
  end

  // Operand and branch selects: WB bit from the match, PC/imm bit from decode.
  always_comb begin
    asel    = SEL_REG;
    bsel    = SEL_REG;
    br1_fwd = 1'b0;
    br2_fwd = 1'b0;
    if (ex_valid) begin
      asel    = (hit1 ? SEL_WB : SEL_REG) | (ex_a_is_pc  ? SEL_PCIMM : SEL_REG);
      bsel    = (hit2 ? SEL_WB : SEL_REG) | (ex_b_is_imm ? SEL_PCIMM : SEL_REG);
      br1_fwd = hit1;
      br2_fwd = hit2;
    end
  end

  // Saturating count of non-stalled cycles in which any forward fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count <= '0;
    end else if (any_hit && !stall && (fwd_count != {XLEN{1'b1}})) begin
      fwd_count <= fwd_count + XLEN'(1);
    end
  end

  assign wb_rd     = wb_q.rd;
  assign wb_regwen = wb_q.regwen;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Scoreboard bench for ex_forward_ctrl: a 32-bit and a 4-bit instance share
// stimulus; a register-level model predicts every cycle's outputs.
module tb_ex_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_regwen, ex_a_is_pc, ex_b_is_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;

  logic [1:0]  asel_w, bsel_w, asel_n, bsel_n;
  logic        br1_w, br2_w, br1_n, br2_n;
  logic [4:0]  wb_rd_w, wb_rd_n;
  logic        wb_regwen_w, wb_regwen_n;
  logic [31:0] cnt_w;
  logic [3:0]  cnt_n;

  always #5 clk = ~clk;

  ex_forward_ctrl #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwen(ex_regwen),
    .ex_a_is_pc(ex_a_is_pc), .ex_b_is_imm(ex_b_is_imm),
    .asel(asel_w), .bsel(bsel_w), .br1_fwd(br1_w), .br2_fwd(br2_w),
    .wb_rd(wb_rd_w), .wb_regwen(wb_regwen_w), .fwd_count(cnt_w)
  );

  ex_forward_ctrl #(.XLEN(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwen(ex_regwen),
    .ex_a_is_pc(ex_a_is_pc), .ex_b_is_imm(ex_b_is_imm),
    .asel(asel_n), .bsel(bsel_n), .br1_fwd(br1_n), .br2_fwd(br2_n),
    .wb_rd(wb_rd_n), .wb_regwen(wb_regwen_n), .fwd_count(cnt_n)
  );

  typedef struct {
    int      asel;
    int      bsel;
    int      br1;
    int      br2;
    int      wb_rd;
    int      wb_regwen;
    longint  cnt32;
    longint  cnt4;
  } exp_t;

  exp_t    sb_q[$];
  int      vectors = 0;
  int      miscompares = 0;

  // Reference state: which register the instruction now in WB will write.
  bit      model_known = 0;
  bit      wb_live = 0;
  int      wb_reg = 0;
  longint  fwd_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of EX inputs, predict this cycle's outputs, then advance the model.
  task automatic drive(input bit v, input int r1, input int r2, input int rd,
                       input bit wen, input bit apc, input bit bimm,
                       input bit st, input bit fl, input bit rs);
    exp_t e;
    bit   h1, h2;
    @(posedge clk);
    #1;
    rst = rs; stall = st; flush = fl; ex_valid = v;
    ex_rs1 = 5'(r1); ex_rs2 = 5'(r2); ex_rd = 5'(rd);
    ex_regwen = wen; ex_a_is_pc = apc; ex_b_is_imm = bimm;
    h1 = v && wb_live && (wb_reg == r1);
    h2 = v && wb_live && (wb_reg == r2);
    if (model_known) begin
      e.asel      = v ? (h1 ? 2 : 0) + (apc  ? 1 : 0) : 0;
      e.bsel      = v ? (h2 ? 2 : 0) + (bimm ? 1 : 0) : 0;
      e.br1       = h1 ? 1 : 0;
      e.br2       = h2 ? 1 : 0;
      e.wb_rd     = wb_reg;
      e.wb_regwen = wb_live ? 1 : 0;
      e.cnt32     = fwd_cycles;
      e.cnt4      = (fwd_cycles > 15) ? 15 : fwd_cycles;
      sb_q.push_back(e);
    end
    if (rs) begin
      wb_live = 0; wb_reg = 0; fwd_cycles = 0; model_known = 1;
    end else begin
      if ((h1 || h2) && !st && fwd_cycles < 64'hFFFF_FFFF) fwd_cycles++;
      if (!st) begin
        wb_reg  = rd;
        wb_live = v && wen && !fl && (rd != 0);
      end else if (fl) begin
        wb_live = 0;
      end
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("asel",       64'(asel_w),      64'(e.asel));
      check("bsel",       64'(bsel_w),      64'(e.bsel));
      check("br1_fwd",    64'(br1_w),       64'(e.br1));
      check("br2_fwd",    64'(br2_w),       64'(e.br2));
      check("wb_rd",      64'(wb_rd_w),     64'(e.wb_rd));
      check("wb_regwen",  64'(wb_regwen_w), 64'(e.wb_regwen));
      check("fwd_count",  64'(cnt_w),       64'(e.cnt32));
      check("asel_x4",    64'(asel_n),      64'(e.asel));
      check("bsel_x4",    64'(bsel_n),      64'(e.bsel));
      check("fwd_count_x4", 64'(cnt_n),     64'(e.cnt4));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_regwen = 0;
    ex_a_is_pc = 0; ex_b_is_imm = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;

    // Reset, then check idle outputs for arbitrary EX addresses.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    drive(1, 4, 12, 0, 0, 0, 0, 0, 0, 0);

    // Forward rd=5 into operand A only.
    drive(1, 1, 2, 5, 1, 0, 0, 0, 0, 0);
    drive(1, 5, 6, 0, 0, 0, 0, 0, 0, 0);

    // Forward rd=7 into both operands with PC/imm also selected: code 11.
    drive(1, 1, 2, 7, 1, 0, 0, 0, 0, 0);
    drive(1, 7, 7, 0, 0, 1, 1, 0, 0, 0);

    // Writer to x0 must never forward.
    drive(1, 1, 2, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Flushed writer to x9 must not forward.
    drive(1, 1, 2, 9, 1, 0, 0, 0, 1, 0);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);

    // Capture rd=3, hold it under stall for two cycles, then reset mid-stall.
    drive(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 8, 1, 0, 0, 1, 0, 0);
    drive(1, 3, 0, 8, 1, 0, 0, 1, 0, 0);
    drive(1, 3, 0, 8, 1, 0, 0, 1, 0, 1);
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);

    // Flush under stall clears a held writer.
    drive(1, 1, 2, 4, 1, 0, 0, 0, 0, 0);
    drive(1, 4, 4, 6, 1, 0, 0, 1, 1, 0);
    drive(1, 4, 4, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back forwarding pushes the 4-bit counter past saturation.
    for (int i = 0; i < 24; i++) drive(1, 10, 11, 10, 1, 0, 0, 0, 0, 0);

    // Randomized traffic over a small register window to provoke matches.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
